// File: rtl/mgmt_irq_controller.sv
// Management interrupt aggregator: per-source enable, edge/level trigger and pending latch,
// one registered irq pin with a minimum deassert time, and a 16-bit APB completer for firmware.
module mgmt_irq_controller #(
    parameter int NUM_IRQ        = 16,
    parameter int HOLDOFF_CYCLES = 32,
    parameter int ADDR_WIDTH     = 10
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NUM_IRQ-1:0]    irq_in,
    input  logic                  psel,
    input  logic                  penable,
    input  logic                  pwrite,
    input  logic [ADDR_WIDTH-1:0] paddr,
    input  logic [15:0]           pwdata,
    output logic [15:0]           prdata,
    output logic                  pready,
    output logic                  pslverr,
    output logic                  irq
);

    localparam int CNT_W = (HOLDOFF_CYCLES > 0) ? $clog2(HOLDOFF_CYCLES + 1) : 1;

    typedef enum logic [2:0] {
        REG_RAW     = 3'd0,
        REG_PENDING = 3'd1,
        REG_ENABLE  = 3'd2,
        REG_EDGE    = 3'd3,
        REG_ACTIVE  = 3'd4,
        REG_VECTOR  = 3'd5,
        REG_FORCE   = 3'd6,
        REG_NONE    = 3'd7
    } reg_sel_e;

    logic [NUM_IRQ-1:0]    in_prev;
    logic [NUM_IRQ-1:0]    pending;
    logic [NUM_IRQ-1:0]    enable;
    logic [NUM_IRQ-1:0]    trig_edge;
    logic [CNT_W-1:0]      hold_cnt;

    logic                  access;
    logic                  wr_en;
    logic [ADDR_WIDTH-2:0] word;
    reg_sel_e              sel;
    logic [NUM_IRQ-1:0]    active;
    logic                  active_any;
    logic [NUM_IRQ-1:0]    pend_clr;
    logic [NUM_IRQ-1:0]    pend_set;
    logic [NUM_IRQ-1:0]    pending_next;
    logic [15:0]           vector;
    logic [15:0]           rdata;
    logic                  rd_err;
    logic                  unused_bits;

    function automatic logic [15:0] ext(input logic [NUM_IRQ-1:0] v);
        logic [15:0] r;
        r              = '0;
        r[NUM_IRQ-1:0] = v;
        return r;
    endfunction

    // Byte address bit 0 carries no information for 16-bit registers.
    assign unused_bits = paddr[0];
    assign word        = paddr[ADDR_WIDTH-1:1];
    assign sel         = (word < (ADDR_WIDTH-1)'(7)) ? reg_sel_e'(word[2:0]) : REG_NONE;

    assign access     = psel & penable & ~rst;
    assign wr_en      = access & pwrite;
    assign active     = pending & enable;
    assign active_any = |active;

    assign pend_clr = (wr_en && sel == REG_PENDING) ? pwdata[NUM_IRQ-1:0] : '0;
    assign pend_set = (irq_in & ~trig_edge)
                    | (irq_in & ~in_prev & trig_edge)
                    | ((wr_en && sel == REG_FORCE) ? pwdata[NUM_IRQ-1:0] : '0);
    // A new trigger outranks a W1C landing on the same bit in the same cycle.
    assign pending_next = (pending & ~pend_clr) | pend_set;

    always_comb begin
        vector = '0;
        for (int i = NUM_IRQ - 1; i >= 0; i--) begin
            if (active[i]) vector = 16'h8000 | 16'(i);
        end
    end

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path leaves a latch behind.
        rdata  = '0;
        rd_err = 1'b0;
        case (sel)
            REG_RAW:     begin rdata = ext(irq_in);  rd_err = pwrite; end
            REG_PENDING: rdata = ext(pending);
            REG_ENABLE:  rdata = ext(enable);
            REG_EDGE:    rdata = ext(trig_edge);
            REG_ACTIVE:  begin rdata = ext(active);  rd_err = pwrite; end
            REG_VECTOR:  begin rdata = vector;       rd_err = pwrite; end
            REG_FORCE:   rdata = '0;
            default:     rd_err = 1'b1;
        endcase
    end

    assign pready  = access;
    assign pslverr = access & rd_err;
    assign prdata  = access ? rdata : '0;

    always_ff @(posedge clk) begin
        // NOTE: reset is sampled on the clock edge, so it only takes effect at the next rising edge.
        if (rst) begin
            in_prev   <= '0;
            pending   <= '0;
            enable    <= '0;
            trig_edge <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register here sees pre-edge values.
            in_prev <= irq_in;
            pending <= pending_next;
            if (wr_en && sel == REG_ENABLE) enable    <= pwdata[NUM_IRQ-1:0];
            if (wr_en && sel == REG_EDGE)   trig_edge <= pwdata[NUM_IRQ-1:0];
        end
    end

    // The holdoff counter guarantees the MCU sees at least HOLDOFF_CYCLES+1 low cycles.
    always_ff @(posedge clk) begin
        if (rst) begin
            irq      <= 1'b0;
            hold_cnt <= '0;
        end else if (irq) begin
            if (!active_any) begin
                irq      <= 1'b0;
                hold_cnt <= CNT_W'(HOLDOFF_CYCLES);
            end
        end else if (hold_cnt != '0) begin
            hold_cnt <= hold_cnt - CNT_W'(1);
        end else if (active_any) begin
            irq <= 1'b1;
        end
    end

endmodule

// File: tb/tb_mgmt_irq_controller.sv
// Self-checking bench for mgmt_irq_controller: directed scenarios plus random traffic,
// all compared against a cycle-level behavioural model of the register/irq rules.
module tb_mgmt_irq_controller;

    localparam int N    = 16;
    localparam int HOLD = 32;
    localparam int AW   = 10;

    logic          clk = 1'b0;
    logic          rst;
    logic [N-1:0]  irq_in;
    logic          psel, penable, pwrite;
    logic [AW-1:0] paddr;
    logic [15:0]   pwdata;
    logic [15:0]   prdata;
    logic          pready, pslverr, irq;

    int errors = 0;
    int checks = 0;

    // Reference model state.
    logic [15:0] m_prev, m_pend, m_en, m_edge;
    logic        m_irq;
    int          cyc    = 0;
    int          t_fall = -1000000;

    always #5 clk = ~clk;

    mgmt_irq_controller #(.NUM_IRQ(N), .HOLDOFF_CYCLES(HOLD), .ADDR_WIDTH(AW)) dut (
        .clk(clk), .rst(rst), .irq_in(irq_in),
        .psel(psel), .penable(penable), .pwrite(pwrite),
        .paddr(paddr), .pwdata(pwdata),
        .prdata(prdata), .pready(pready), .pslverr(pslverr), .irq(irq)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [15:0] m_vector();
        for (int i = 0; i < N; i++)
            if (m_pend[i] && m_en[i]) return 16'h8000 | 16'(i);
        return 16'h0000;
    endfunction

    // Returns {pslverr, prdata} expected for an access phase at address a.
    function automatic logic [16:0] m_read(input logic [AW-1:0] a, input logic is_wr);
        int          w = int'(a) >> 1;
        logic [15:0] d = 16'h0;
        logic        e = 1'b0;
        case (w)
            0: d = irq_in;
            1: d = m_pend;
            2: d = m_en;
            3: d = m_edge;
            4: d = m_pend & m_en;
            5: d = m_vector();
            6: d = 16'h0;
            default: e = 1'b1;
        endcase
        if (is_wr && (w == 0 || w == 4 || w == 5)) e = 1'b1;
        return {e, d};
    endfunction

    // Applies the rules for one rising edge using the inputs present before it.
    task automatic model_step();
        int          w;
        logic        wr, act;
        logic [15:0] nxt;
        if (rst) begin
            m_prev = '0; m_pend = '0; m_en = '0; m_edge = '0;
            m_irq  = 1'b0;
            t_fall = -1000000;
            cyc++;
            return;
        end
        w   = int'(paddr) >> 1;
        wr  = psel && penable && pwrite;
        act = (m_pend & m_en) != 16'h0;
        for (int i = 0; i < N; i++) begin
            logic trig, frc, clr;
            trig   = irq_in[i] && (!m_edge[i] || !m_prev[i]);
            frc    = wr && w == 6 && pwdata[i];
            clr    = wr && w == 1 && pwdata[i];
            nxt[i] = trig || frc || (m_pend[i] && !clr);
        end
        m_pend = nxt;
        if (m_irq && !act) begin
            m_irq  = 1'b0;
            t_fall = cyc;
        end else if (!m_irq && act && (cyc - t_fall) > HOLD) begin
            m_irq = 1'b1;
        end
        if (wr && w == 2) m_en   = pwdata;
        if (wr && w == 3) m_edge = pwdata;
        m_prev = irq_in;
        cyc++;
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        check("irq", irq, m_irq);
    endtask

    task automatic apb(input logic is_wr, input logic [AW-1:0] a, input logic [15:0] d,
                       output logic [15:0] rd, output logic err);
        logic [16:0] e;
        psel = 1'b1; penable = 1'b0; pwrite = is_wr; paddr = a; pwdata = d;
        tick();
        penable = 1'b1;
        #1;
        e = m_read(a, is_wr);
        check("pready", pready, 1'b1);
        check($sformatf("pslverr@%0h", a), pslverr, e[16]);
        if (!is_wr) check($sformatf("prdata@%0h", a), prdata, e[15:0]);
        rd  = prdata;
        err = pslverr;
        tick();
        psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    endtask

    task automatic reg_wr(input logic [AW-1:0] a, input logic [15:0] d);
        logic [15:0] rd;
        logic        err;
        apb(1'b1, a, d, rd, err);
    endtask

    task automatic reg_rd(input logic [AW-1:0] a, output logic [15:0] rd);
        logic err;
        apb(1'b0, a, 16'h0, rd, err);
    endtask

    task automatic wait_irq_high(input string tag);
        for (int k = 0; k < 100 && !irq; k++) tick();
        check(tag, irq, 1'b1);
    endtask

    initial begin
        logic [15:0] v, v2;
        logic        err;
        int          low;

        rst = 1'b1; irq_in = '0; psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
        paddr = '0; pwdata = '0;
        tick(); tick();
        rst = 1'b0;

        // Reset state of every register.
        for (int a = 0; a <= 12; a += 2) reg_rd(AW'(a), v);
        reg_rd(10'h002, v); check("reset_pending", v, 16'h0);

        // Edge mode: one-cycle pulse on source 0.
        reg_wr(10'h006, 16'h0001);
        reg_wr(10'h004, 16'h0001);
        irq_in[0] = 1'b1;
        tick();
        irq_in[0] = 1'b0;
        check("edge_irq_lat1", irq, 1'b0);
        tick();
        check("edge_irq_lat2", irq, 1'b1);
        reg_rd(10'h002, v); check("edge_pending", v, 16'h0001);
        reg_rd(10'h00A, v); check("edge_vector", v, 16'h8000);
        reg_wr(10'h002, 16'h0001);
        tick();
        check("edge_irq_clr", irq, 1'b0);
        reg_rd(10'h002, v); check("edge_pending_clr", v, 16'h0000);

        // Level mode re-arm on source 2.
        reg_wr(10'h004, 16'h0004);
        irq_in[2] = 1'b1;
        tick(); tick();
        reg_wr(10'h002, 16'h0004);
        reg_rd(10'h002, v); check("level_rearm", v, 16'h0004);
        irq_in[2] = 1'b0;
        reg_wr(10'h002, 16'h0004);
        reg_rd(10'h002, v); check("level_clr", v, 16'h0000);
        for (int k = 0; k < 40; k++) tick();
        check("level_irq_low", irq, 1'b0);

        // Holdoff: clear, re-trigger at once, measure low time.
        reg_wr(10'h004, 16'h0001);
        irq_in[0] = 1'b1; tick(); irq_in[0] = 1'b0;
        wait_irq_high("hold_setup_irq");
        reg_wr(10'h002, 16'h0001);
        irq_in[0] = 1'b1; tick(); irq_in[0] = 1'b0;
        check("hold_fell", irq, 1'b0);
        low = 1;
        for (int k = 0; k < 100 && !irq; k++) begin
            tick();
            if (!irq) low++;
        end
        check("hold_low_cycles", low, HOLD + 1);
        check("hold_reassert", irq, 1'b1);

        // Priority, masking and set-wins.
        reg_wr(10'h004, 16'h0000);
        reg_wr(10'h002, 16'hFFFF);
        reg_wr(10'h00C, 16'h0088);
        reg_wr(10'h004, 16'h0080);
        reg_rd(10'h00A, v); check("vec_bit7", v, 16'h8007);
        reg_wr(10'h004, 16'h0088);
        reg_rd(10'h00A, v); check("vec_bit3", v, 16'h8003);
        reg_wr(10'h004, 16'h0000);
        tick(); tick();
        check("mask_irq_low", irq, 1'b0);
        reg_rd(10'h00A, v); check("vec_none", v, 16'h0000);
        reg_rd(10'h002, v); check("mask_pending", v, 16'h0088);
        reg_wr(10'h006, 16'h0009);
        reg_wr(10'h002, 16'h0008);
        reg_rd(10'h002, v); check("w1c_bit3", v, 16'h0080);
        psel = 1'b1; pwrite = 1'b1; paddr = 10'h002; pwdata = 16'h0008; penable = 1'b0;
        tick();
        penable = 1'b1; irq_in[3] = 1'b1;
        tick();
        psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
        irq_in[3] = 1'b0;
        reg_rd(10'h002, v); check("set_wins", v, 16'h0088);

        // FORCE and error responses.
        reg_wr(10'h00C, 16'h0010);
        reg_rd(10'h002, v); check("force_bit4", v & 16'h0010, 16'h0010);
        apb(1'b0, 10'h00E, 16'h0, v, err);
        check("bad_addr_err", err, 1'b1);
        check("bad_addr_data", v, 16'h0000);
        reg_rd(10'h004, v);
        apb(1'b1, 10'h008, 16'hFFFF, v2, err);
        check("ro_write_err", err, 1'b1);
        reg_rd(10'h004, v2); check("ro_write_noeff", v2, v);

        // Random traffic against the model.
        for (int it = 0; it < 400; it++) begin
            irq_in = N'($urandom & $urandom & $urandom);
            case ($urandom_range(0, 3))
                0: tick();
                1: reg_rd(AW'($urandom_range(0, 17)), v);
                2: reg_wr(AW'($urandom_range(0, 15)), 16'($urandom));
                default: begin
                    if ($urandom_range(0, 4) == 0) reg_rd(AW'($urandom), v);
                    else reg_wr(10'h004, 16'($urandom));
                end
            endcase
        end
        irq_in = '0;

        // Reset mid-operation: pending set, holdoff running, write in access phase.
        reg_wr(10'h004, 16'hFFFF);
        reg_wr(10'h00C, 16'h00F0);
        wait_irq_high("rst_setup_irq");
        reg_wr(10'h002, 16'hFFFF);
        reg_wr(10'h00C, 16'h0003);
        check("rst_holdoff_low", irq, 1'b0);
        psel = 1'b1; pwrite = 1'b1; paddr = 10'h006; pwdata = 16'h1234; penable = 1'b0;
        tick();
        penable = 1'b1; rst = 1'b1;
        #1;
        check("rst_pready", pready, 1'b0);
        check("rst_pslverr", pslverr, 1'b0);
        check("rst_prdata", prdata, 16'h0000);
        tick();
        rst = 1'b0; psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
        check("rst_irq", irq, 1'b0);
        for (int a = 0; a <= 12; a += 2) reg_rd(AW'(a), v);
        reg_rd(10'h006, v); check("rst_edge_nocommit", v, 16'h0000);
        reg_rd(10'h004, v); check("rst_enable", v, 16'h0000);
        // Holdoff counter must be cleared too: a fresh force raises irq with no delay.
        reg_wr(10'h004, 16'h0001);
        reg_wr(10'h00C, 16'h0001);
        tick();
        check("rst_no_holdoff", irq, 1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

endmodule
